// File: rtl/id_ex_stage_if.sv
// Bus between the decode stage and the ID/EX register: decoded fields in,
// EX/MEM and MEM/WB bypass sources in, ALU-facing EX fields and stall out.
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          id_valid;
    logic [RW-1:0] id_rs_addr;
    logic [RW-1:0] id_rt_addr;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [DW-1:0] id_imm;
    logic          id_alu_src;
    logic [3:0]    id_alu_cnt;
    logic [4:0]    id_shamt;
    logic [RW-1:0] id_rd_addr;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          id_mem_write;

    logic          exm_reg_write;
    logic [RW-1:0] exm_rd_addr;
    logic [DW-1:0] exm_result;
    logic          wb_reg_write;
    logic [RW-1:0] wb_rd_addr;
    logic [DW-1:0] wb_data;

    logic          stall_o;
    logic          ex_valid;
    logic [3:0]    ex_alu_cnt;
    logic [4:0]    ex_shamt;
    logic [DW-1:0] ex_input1;
    logic [DW-1:0] ex_input2;
    logic [DW-1:0] ex_store_data;
    logic [RW-1:0] ex_rd_addr;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
               id_alu_src, id_alu_cnt, id_shamt, id_rd_addr,
               id_reg_write, id_mem_read, id_mem_write,
               exm_reg_write, exm_rd_addr, exm_result,
               wb_reg_write, wb_rd_addr, wb_data,
        input  stall_o, ex_valid, ex_alu_cnt, ex_shamt, ex_input1, ex_input2,
               ex_store_data, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
               id_alu_src, id_alu_cnt, id_shamt, id_rd_addr,
               id_reg_write, id_mem_read, id_mem_write,
               exm_reg_write, exm_rd_addr, exm_result,
               wb_reg_write, wb_rd_addr, wb_data,
        output stall_o, ex_valid, ex_alu_cnt, ex_shamt, ex_input1, ex_input2,
               ex_store_data, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass and load-use stall detection.
// Define ID_EX_FORWARD_EN for full EX/MEM + MEM/WB bypass; otherwise hazards stall.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         hold,
    id_ex_stage_if.slave bus
);
    logic          r_valid;
    logic          r_reg_write;
    logic          r_mem_read;
    logic          r_mem_write;
    logic          r_alu_src;
    logic [3:0]    r_alu_cnt;
    logic [4:0]    r_shamt;
    logic [RW-1:0] r_rd_addr;
    logic [RW-1:0] r_rs_addr;
    logic [RW-1:0] r_rt_addr;
    logic [DW-1:0] r_rs_data;
    logic [DW-1:0] r_rt_data;
    logic [DW-1:0] r_imm;

    logic          w_load_use;
    logic          w_raw_stall;
    logic          w_stall;
    logic [DW-1:0] w_rs_fwd;
    logic [DW-1:0] w_rt_fwd;

    assign w_load_use = bus.id_valid && r_valid && r_mem_read && (r_rd_addr != '0) &&
                        ((r_rd_addr == bus.id_rs_addr) || (r_rd_addr == bus.id_rt_addr));

`ifdef ID_EX_FORWARD_EN
    logic w_rs_exm, w_rs_wb, w_rt_exm, w_rt_wb;

    assign w_rs_exm = bus.exm_reg_write && (bus.exm_rd_addr == r_rs_addr) && (r_rs_addr != '0);
    assign w_rs_wb  = bus.wb_reg_write  && (bus.wb_rd_addr  == r_rs_addr) && (r_rs_addr != '0);
    assign w_rt_exm = bus.exm_reg_write && (bus.exm_rd_addr == r_rt_addr) && (r_rt_addr != '0);
    assign w_rt_wb  = bus.wb_reg_write  && (bus.wb_rd_addr  == r_rt_addr) && (r_rt_addr != '0);

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    assign w_rs_fwd = w_rs_exm ? bus.exm_result : (w_rs_wb ? bus.wb_data : r_rs_data);
    assign w_rt_fwd = w_rt_exm ? bus.exm_result : (w_rt_wb ? bus.wb_data : r_rt_data);
    assign w_raw_stall = 1'b0;
`else
    logic w_rs_hit, w_rt_hit;
    logic w_unused_bypass;

    // No bypass: hold decode until any in-flight producer has written the register file.
    assign w_rs_hit = (bus.id_rs_addr != '0) &&
                      ((r_valid && r_reg_write && (r_rd_addr == bus.id_rs_addr)) ||
                       (bus.exm_reg_write && (bus.exm_rd_addr == bus.id_rs_addr)));
    assign w_rt_hit = (bus.id_rt_addr != '0) &&
                      ((r_valid && r_reg_write && (r_rd_addr == bus.id_rt_addr)) ||
                       (bus.exm_reg_write && (bus.exm_rd_addr == bus.id_rt_addr)));
    assign w_raw_stall = bus.id_valid && (w_rs_hit || w_rt_hit);
    assign w_rs_fwd = r_rs_data;
    assign w_rt_fwd = r_rt_data;
    assign w_unused_bypass = ^{bus.exm_result, bus.wb_data, bus.wb_reg_write,
                               bus.wb_rd_addr, r_rs_addr, r_rt_addr};
`endif

    assign w_stall = w_load_use || w_raw_stall;

    // Valid and side-effecting control: flush > hold > bubble > load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (flush || (!hold && w_stall)) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (!hold) begin
            r_valid     <= bus.id_valid;
            r_reg_write <= bus.id_reg_write && bus.id_valid;
            r_mem_read  <= bus.id_mem_read  && bus.id_valid;
            r_mem_write <= bus.id_mem_write && bus.id_valid;
        end
    end

    // Data fields load whenever not frozen; they are meaningless while r_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_src <= 1'b0;
            r_alu_cnt <= '0;
            r_shamt   <= '0;
            r_rd_addr <= '0;
            r_rs_addr <= '0;
            r_rt_addr <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
        end else if (flush || !hold) begin
            r_alu_src <= bus.id_alu_src;
            r_alu_cnt <= bus.id_alu_cnt;
            r_shamt   <= bus.id_shamt;
            r_rd_addr <= bus.id_rd_addr;
            r_rs_addr <= bus.id_rs_addr;
            r_rt_addr <= bus.id_rt_addr;
            r_rs_data <= bus.id_rs_data;
            r_rt_data <= bus.id_rt_data;
            r_imm     <= bus.id_imm;
        end
    end

    assign bus.stall_o       = w_stall;
    assign bus.ex_valid      = r_valid;
    assign bus.ex_alu_cnt    = r_alu_cnt;
    assign bus.ex_shamt      = r_shamt;
    assign bus.ex_input1     = w_rs_fwd;
    assign bus.ex_input2     = r_alu_src ? r_imm : w_rt_fwd;
    assign bus.ex_store_data = w_rt_fwd;
    assign bus.ex_rd_addr    = r_rd_addr;
    assign bus.ex_reg_write  = r_reg_write;
    assign bus.ex_mem_read   = r_mem_read;
    assign bus.ex_mem_write  = r_mem_write;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/forwarding scenarios followed
// by randomized traffic compared against an instruction-level reference model.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic hold = 1'b0;

    id_ex_stage_if #(.DW(DW), .RW(RW)) bus ();

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .hold  (hold),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference: the instruction sitting in the EX slot.
    typedef struct {
        logic          valid;
        logic          rw, mr, mw, alu_src;
        logic [3:0]    alu_cnt;
        logic [4:0]    shamt;
        logic [RW-1:0] rd, rs, rt;
        logic [DW-1:0] rsd, rtd, imm;
    } slot_t;

    slot_t m_cur, m_next;

    function automatic logic [DW-1:0] exp_operand(input logic [RW-1:0] src, input logic [DW-1:0] rf);
`ifdef ID_EX_FORWARD_EN
        if (src != 0 && bus.exm_reg_write && bus.exm_rd_addr == src) return bus.exm_result;
        if (src != 0 && bus.wb_reg_write && bus.wb_rd_addr == src) return bus.wb_data;
`endif
        return rf;
    endfunction

    function automatic logic src_busy(input slot_t s, input logic [RW-1:0] src);
        if (src == 0) return 1'b0;
        if (s.valid && s.mr && s.rd == src) return 1'b1;
`ifndef ID_EX_FORWARD_EN
        if (s.valid && s.rw && s.rd == src) return 1'b1;
        if (bus.exm_reg_write && bus.exm_rd_addr == src) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic exp_stall(input slot_t s);
        return bus.id_valid && (src_busy(s, bus.id_rs_addr) || src_busy(s, bus.id_rt_addr));
    endfunction

    function automatic slot_t advance(input slot_t s);
        slot_t n;
        if (hold && !flush) return s;
        n.valid   = bus.id_valid;
        n.rw      = bus.id_reg_write & bus.id_valid;
        n.mr      = bus.id_mem_read & bus.id_valid;
        n.mw      = bus.id_mem_write & bus.id_valid;
        n.alu_src = bus.id_alu_src;
        n.alu_cnt = bus.id_alu_cnt;
        n.shamt   = bus.id_shamt;
        n.rd      = bus.id_rd_addr;
        n.rs      = bus.id_rs_addr;
        n.rt      = bus.id_rt_addr;
        n.rsd     = bus.id_rs_data;
        n.rtd     = bus.id_rt_data;
        n.imm     = bus.id_imm;
        if (flush || exp_stall(s)) begin
            n.valid = 1'b0; n.rw = 1'b0; n.mr = 1'b0; n.mw = 1'b0;
        end
        return n;
    endfunction

    task automatic compare_slot(input slot_t s, input string pfx);
        logic [DW-1:0] rt_val;
        check({pfx, "stall"}, 32'(bus.stall_o), 32'(exp_stall(s)));
        check({pfx, "valid"}, 32'(bus.ex_valid), 32'(s.valid));
        check({pfx, "reg_write"}, 32'(bus.ex_reg_write), 32'(s.rw));
        check({pfx, "mem_read"}, 32'(bus.ex_mem_read), 32'(s.mr));
        check({pfx, "mem_write"}, 32'(bus.ex_mem_write), 32'(s.mw));
        if (s.valid) begin
            rt_val = exp_operand(s.rt, s.rtd);
            check({pfx, "input1"}, bus.ex_input1, exp_operand(s.rs, s.rsd));
            check({pfx, "input2"}, bus.ex_input2, s.alu_src ? s.imm : rt_val);
            check({pfx, "store_data"}, bus.ex_store_data, rt_val);
            check({pfx, "alu_cnt"}, 32'(bus.ex_alu_cnt), 32'(s.alu_cnt));
            check({pfx, "shamt"}, 32'(bus.ex_shamt), 32'(s.shamt));
            check({pfx, "rd_addr"}, 32'(bus.ex_rd_addr), 32'(s.rd));
        end
    endtask

    task automatic set_idle();
        flush = 1'b0; hold = 1'b0;
        bus.id_valid = 1'b0; bus.id_rs_addr = '0; bus.id_rt_addr = '0;
        bus.id_rs_data = '0; bus.id_rt_data = '0; bus.id_imm = '0;
        bus.id_alu_src = 1'b0; bus.id_alu_cnt = '0; bus.id_shamt = '0; bus.id_rd_addr = '0;
        bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0; bus.id_mem_write = 1'b0;
        bus.exm_reg_write = 1'b0; bus.exm_rd_addr = '0; bus.exm_result = '0;
        bus.wb_reg_write = 1'b0; bus.wb_rd_addr = '0; bus.wb_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        flush = ($urandom_range(0, 11) == 0);
        hold  = ($urandom_range(0, 7) == 0);
        bus.id_valid     = ($urandom_range(0, 3) != 0);
        bus.id_rs_addr   = RW'($urandom_range(0, 3));
        bus.id_rt_addr   = RW'($urandom_range(0, 3));
        bus.id_rs_data   = $urandom;
        bus.id_rt_data   = $urandom;
        bus.id_imm       = $urandom;
        bus.id_alu_src   = $urandom_range(0, 1) == 1;
        bus.id_alu_cnt   = 4'($urandom);
        bus.id_shamt     = 5'($urandom);
        bus.id_rd_addr   = RW'($urandom_range(0, 3));
        bus.id_reg_write = $urandom_range(0, 1) == 1;
        bus.id_mem_read  = ($urandom_range(0, 2) == 0);
        bus.id_mem_write = ($urandom_range(0, 3) == 0);
        bus.exm_reg_write = $urandom_range(0, 1) == 1;
        bus.exm_rd_addr   = RW'($urandom_range(0, 3));
        bus.exm_result    = $urandom;
        bus.wb_reg_write  = $urandom_range(0, 1) == 1;
        bus.wb_rd_addr    = RW'($urandom_range(0, 3));
        bus.wb_data       = $urandom;
    endtask

    initial begin
        logic [DW-1:0] exp_a;
        set_idle();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("rst_stall", 32'(bus.stall_o), 32'd0);
        check("rst_valid", 32'(bus.ex_valid), 32'd0);
        check("rst_ctrl", {29'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, 32'd0);
        check("rst_alu_cnt", 32'(bus.ex_alu_cnt), 32'd0);
        check("rst_shamt", 32'(bus.ex_shamt), 32'd0);
        check("rst_rd", 32'(bus.ex_rd_addr), 32'd0);
        check("rst_in1", bus.ex_input1, 32'd0);
        check("rst_in2", bus.ex_input2, 32'd0);
        check("rst_store", bus.ex_store_data, 32'd0);
        $display("txn reset: outputs checked");

        // Bypass priority on rs = 5 holding 0x11.
        bus.id_valid = 1'b1; bus.id_rs_addr = 5'd5; bus.id_rs_data = 32'h11;
        bus.id_rd_addr = 5'd3; bus.id_reg_write = 1'b1;
        tick();
        set_idle();
        bus.exm_reg_write = 1'b1; bus.exm_rd_addr = 5'd5; bus.exm_result = 32'hAAAA0000;
        #1;
`ifdef ID_EX_FORWARD_EN
        exp_a = 32'hAAAA0000;
`else
        exp_a = 32'h11;
`endif
        check("fwd_exm", bus.ex_input1, exp_a);
        bus.wb_reg_write = 1'b1; bus.wb_rd_addr = 5'd5; bus.wb_data = 32'h1234;
        #1;
        check("fwd_dual", bus.ex_input1, exp_a);
        bus.exm_reg_write = 1'b0;
        #1;
`ifdef ID_EX_FORWARD_EN
        exp_a = 32'h1234;
`else
        exp_a = 32'h11;
`endif
        check("fwd_wb", bus.ex_input1, exp_a);
        $display("txn forward: input1=0x%08h", bus.ex_input1);

        // Register 0 is never bypassed.
        set_idle();
        bus.id_valid = 1'b1;
        tick();
        set_idle();
        bus.exm_reg_write = 1'b1; bus.exm_result = 32'hFFFFFFFF;
        bus.wb_reg_write = 1'b1; bus.wb_data = 32'hFFFFFFFF;
        #1;
        check("reg0_in1", bus.ex_input1, 32'd0);
        $display("txn reg0: input1=0x%08h", bus.ex_input1);

        // lw $8 in EX, add using $8 in ID.
        set_idle();
        bus.id_valid = 1'b1; bus.id_mem_read = 1'b1; bus.id_reg_write = 1'b1; bus.id_rd_addr = 5'd8;
        tick();
        set_idle();
        bus.id_valid = 1'b1; bus.id_rs_addr = 5'd8; bus.id_rt_addr = 5'd9;
        bus.id_reg_write = 1'b1; bus.id_rd_addr = 5'd10;
        #1;
        check("lu_stall", 32'(bus.stall_o), 32'd1);
        tick();
        check("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
        check("lu_bubble_rw", 32'(bus.ex_reg_write), 32'd0);
        check("lu_stall_clear", 32'(bus.stall_o), 32'd0);
        tick();
        check("lu_add_valid", 32'(bus.ex_valid), 32'd1);
        check("lu_add_rd", 32'(bus.ex_rd_addr), 32'd10);
        $display("txn load_use: stall then bubble");

        // Flush beats hold; then an immediate op loads.
        set_idle();
        bus.id_valid = 1'b1; bus.id_reg_write = 1'b1; bus.id_mem_write = 1'b1; bus.id_mem_read = 1'b1;
        flush = 1'b1; hold = 1'b1;
        tick();
        set_idle();
        check("flush_valid", 32'(bus.ex_valid), 32'd0);
        check("flush_ctrl", {29'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, 32'd0);
        bus.id_valid = 1'b1; bus.id_alu_src = 1'b1; bus.id_imm = 32'h10; bus.id_rt_data = 32'h77;
        tick();
        check("imm_in2", bus.ex_input2, 32'h10);
        check("imm_store", bus.ex_store_data, 32'h77);
        hold = 1'b1; bus.id_imm = 32'h99; bus.id_valid = 1'b0;
        tick();
        check("hold_in2", bus.ex_input2, 32'h10);
        check("hold_valid", 32'(bus.ex_valid), 32'd1);
        $display("txn flush_hold: input2=0x%08h", bus.ex_input2);

        // Asynchronous reset between clock edges.
        set_idle();
        bus.id_valid = 1'b1; bus.id_reg_write = 1'b1; bus.id_rs_addr = 5'd1; bus.id_rs_data = 32'hDEAD;
        tick();
        set_idle();
        check("pre_rst_valid", 32'(bus.ex_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.ex_valid), 32'd0);
        check("arst_rw", 32'(bus.ex_reg_write), 32'd0);
        check("arst_in1", bus.ex_input1, 32'd0);
        $display("txn async_reset: cleared mid-cycle");
        tick();
        rst_n = 1'b1;

        // Randomized traffic against the slot model.
        m_cur = '{valid: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, alu_src: 1'b0, alu_cnt: '0,
                  shamt: '0, rd: '0, rs: '0, rt: '0, rsd: '0, rtd: '0, imm: '0};
        @(negedge clk);
        m_next = advance(m_cur);
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk);
            m_cur = m_next;
            #1;
            rand_inputs();
            @(negedge clk);
            compare_slot(m_cur, "rnd_");
            $display("txn rnd %0d: valid=%0d stall=%0d in1=0x%08h in2=0x%08h",
                     cyc, bus.ex_valid, bus.stall_o, bus.ex_input1, bus.ex_input2);
            m_next = advance(m_cur);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage for the 5-stage MIPS core.
- Latches decoded operands and control each cycle and resolves RAW hazards with EX/MEM and MEM/WB bypass.
- Detects load-use hazards, stalls decode and inserts bubbles.
- Drives the ALU directly: 4-bit ALU control, 5-bit shamt, two 32-bit operands.

Parameters:
- DW, 32, datapath width
- RW, 5, register address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill the instruction entering EX (branch/jump taken)
- hold  in  1  downstream stall; freeze all stage registers
- id_valid  in  1  decode slot holds a real instruction
- id_rs_addr, id_rt_addr  in  RW  source register numbers
- id_rs_data, id_rt_data  in  DW  register file read data
- id_imm  in  DW  sign/zero-extended immediate
- id_alu_src  in  1  1 selects id_imm as operand 2
- id_alu_cnt  in  4  ALU operation code
- id_shamt  in  5  shift amount
- id_rd_addr  in  RW  destination register
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
- exm_reg_write  in  1  EX/MEM instruction writes a register
- exm_rd_addr  in  RW  EX/MEM destination
- exm_result  in  DW  EX/MEM ALU result
- wb_reg_write  in  1  MEM/WB instruction writes a register
- wb_rd_addr  in  RW  MEM/WB destination
- wb_data  in  DW  MEM/WB writeback value
- stall_o  out  1  load-use stall; decode and PC must hold
- ex_valid  out  1  EX slot valid
- ex_alu_cnt  out  4  to ALU control
- ex_shamt  out  5  to ALU shamt
- ex_input1, ex_input2  out  DW  to ALU operands
- ex_store_data  out  DW  forwarded rt value for stores
- ex_rd_addr  out  RW
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each

Behaviour:
- Reset (rst_n low, asynchronous): all stage registers clear.
  - ex_valid, all ex_* control bits, ex_alu_cnt, ex_shamt, ex_rd_addr = 0.
  - Operands = 0; stall_o = 0 (its inputs are cleared).
- Register update priority each posedge: flush > hold > load-use bubble > load.
  - flush: ex_valid and ex control bits cleared; flush overrides hold.
  - hold: every stage register keeps its value.
  - Bubble: ex_valid and ex control bits cleared; data fields are don't-care but are loaded.
  - Load: all id_* fields are captured. The captured valid is id_valid, and control bits are ANDed with id_valid.
- Latency: one cycle from the ID inputs to the registered EX fields.
- Forwarding outputs are combinational from the registered EX fields and the current exm_*/wb_* inputs.
- Forwarding, per source (rs, rt):
  - EX/MEM match: exm_reg_write and exm_rd_addr == src and src != 0 selects exm_result.
  - Otherwise MEM/WB match (same rule) selects wb_data.
  - Otherwise the registered register-file data is used.
  - EX/MEM has priority when both match.
- ex_input1 = forwarded rs.
- ex_input2 = registered imm when alu_src = 1, else forwarded rt.
- ex_store_data is always the forwarded rt.
- Load-use hazard:
  - stall_o = ex_valid & ex_mem_read & ex_rd_addr != 0 & (ex_rd_addr == id_rs_addr or ex_rd_addr == id_rt_addr) & id_valid.
  - The match is conservative: a stall is raised even when id_alu_src = 1 and rt is unused.
- stall_o with hold: hold wins and registers freeze; stall_o still reflects the frozen EX contents.
- stall_o with flush: the bubble is inserted; stall_o is not masked.
- Register 0 never forwards and never stalls.

Optional Feature:
- Macro ID_EX_FORWARD_EN.
- Defined: full bypass as described above.
- Undefined:
  - exm_*/wb_* data inputs are ignored; operands come from the registered register-file data.
  - stall_o additionally asserts for any RAW hazard between id_rs_addr/id_rt_addr (nonzero) and either the EX-slot destination (ex_valid & ex_reg_write) or exm_rd_addr (exm_reg_write).
  - The register file is write-before-read, so no MEM/WB hazard exists.

Test Plan:
- Reset mid-run: assert rst_n = 0 asynchronously while ex_valid = 1 -> ex_valid, ex_reg_write, ex_input1 go to 0 immediately, before the next clock edge.
- EX/MEM forward: registered rs = 5 and rs data 0x11; exm_reg_write = 1, exm_rd_addr = 5, exm_result = 0xAAAA0000 -> ex_input1 = 0xAAAA0000.
- Dual-match priority: also wb_rd_addr = 5, wb_data = 0x1234 -> ex_input1 = 0xAAAA0000; drop exm_reg_write -> ex_input1 = 0x1234.
- Register 0: rs = 0 with exm_rd_addr = 0, exm_reg_write = 1, exm_result = 0xFFFFFFFF -> ex_input1 = registered data 0.
- Load-use: EX holds lw to $8; ID has add with rs = 8, id_valid = 1:
  - stall_o = 1 that cycle.
  - Next cycle ex_valid = 0 and ex_reg_write = 0.
  - stall_o = 0 after the bubble.
- Flush over hold: flush = 1, hold = 1, valid instruction in ID -> next cycle ex_valid = 0 with all ex control bits 0; alu_src = 1 with id_imm = 0x10 then yields ex_input2 = 0x10.
